// File: rtl/obj_line_sched.sv
// rtl/obj_line_sched.sv - per-scanline object Y-compare scheduler with 16-deep draw queue
//
// Purpose: on each line_start, read the Y byte of the 32 objects in the selected
// bank, keep those whose 16-line span covers the next line, and queue {idx,row}
// for the draw engine in index order.
//
// Ports:
//   clkm_48MHZ, nRESET        clock, async active-low reset
//   line_start, vpos, objex   line strobe; vpos/objex latched on it
//   objoff                    1 = objects enabled (0 scans but queues nothing)
//   ram_addr, ram_rd, ram_q   object RAM read port, data 2 cycles after ram_rd
//   draw_req/idx/row, draw_ack  head-of-queue handshake to the draw engine
//   lnsl, busy, line_objs     line-buffer select, activity, queued count (sat. 16)
//   ovf, line_late, ovf_clr   queue overflow, late line_start, sticky-ovf clear
//
// Build option: OBJSCH_OVF_STICKY_EN makes ovf sticky until ovf_clr.

module obj_line_sched (
  input  logic       clkm_48MHZ,
  input  logic       nRESET,
  input  logic       line_start,
  input  logic [7:0] vpos,
  input  logic       objex,
  input  logic       objoff,
  output logic [7:0] ram_addr,
  output logic       ram_rd,
  input  logic [7:0] ram_q,
  output logic       draw_req,
  output logic [4:0] draw_idx,
  output logic [3:0] draw_row,
  input  logic       draw_ack,
  output logic       lnsl,
  output logic       busy,
  output logic [4:0] line_objs,
  output logic       ovf,
  output logic       line_late,
  input  logic       ovf_clr
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t     state_q;
  logic [5:0] cnt_q;       // cycles since SCAN entry, 0..33
  logic [7:0] vpos_q;
  logic       bank_q;
  logic [8:0] fifo_q [16];
  logic [3:0] wr_ptr_q, rd_ptr_q;
  logic [4:0] count_q;
  logic [7:0] ram_addr_q;
  logic       ram_rd_q, lnsl_q, ovf_q, line_late_q;
  logic [4:0] line_objs_q;

  logic [7:0] sum;
  logic       cmp_v, hit, pop, push_ok, drop;
  logic [4:0] cmp_idx, count_d;
  logic [8:0] head;

  always_comb begin
    sum      = ram_q + vpos_q + 8'd1;
    // Data for the read issued at cnt-2 is on ram_q now; reads issued before an
    // abort land at cnt 0/1 and are never compared.
    cmp_v    = (state_q == SCAN) && (cnt_q >= 6'd2) && !line_start;
    cmp_idx  = 5'(cnt_q - 6'd2);
    hit      = cmp_v && objoff && (sum[7:4] == 4'hF);
    // Gated by line_start so an aborting line drops the request immediately.
    draw_req = (count_q != 5'd0) && (state_q != IDLE) && !line_start;
    pop      = draw_req && draw_ack;
    push_ok  = hit && ((count_q != 5'd16) || pop);
    drop     = hit && !push_ok;
    count_d  = count_q + {4'b0, push_ok} - {4'b0, pop};
    head     = fifo_q[rd_ptr_q];
  end

  assign draw_idx  = head[8:4];
  assign draw_row  = head[3:0];
  assign busy      = (state_q != IDLE);
  assign ram_addr  = ram_addr_q;
  assign ram_rd    = ram_rd_q;
  assign lnsl      = lnsl_q;
  assign line_objs = line_objs_q;
  assign ovf       = ovf_q;
  assign line_late = line_late_q;

`ifndef OBJSCH_OVF_STICKY_EN
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
`endif

  always_ff @(posedge clkm_48MHZ or negedge nRESET) begin
    if (!nRESET) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      vpos_q      <= '0;
      bank_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ram_addr_q  <= '0;
      ram_rd_q    <= 1'b0;
      lnsl_q      <= 1'b0;
      ovf_q       <= 1'b0;
      line_late_q <= 1'b0;
      line_objs_q <= '0;
      for (int i = 0; i < 16; i++) fifo_q[i] <= '0;
    end else begin
      line_late_q <= 1'b0;
      if (line_start) begin
        line_late_q <= (state_q != IDLE);
        state_q     <= SCAN;
        cnt_q       <= '0;
        vpos_q      <= vpos;
        bank_q      <= objex;
        lnsl_q      <= ~lnsl_q;
        wr_ptr_q    <= '0;
        rd_ptr_q    <= '0;
        count_q     <= '0;
        line_objs_q <= '0;
        ram_rd_q    <= 1'b1;
        ram_addr_q  <= {objex, 5'd0, 2'b00};
      end else begin
        if (push_ok) begin
          fifo_q[wr_ptr_q] <= {cmp_idx, sum[3:0]};
          wr_ptr_q         <= wr_ptr_q + 4'd1;
          if (line_objs_q != 5'd16) line_objs_q <= line_objs_q + 5'd1;
        end
        if (pop) rd_ptr_q <= rd_ptr_q + 4'd1;
        count_q <= count_d;
        case (state_q)
          SCAN: begin
            cnt_q      <= cnt_q + 6'd1;
            ram_rd_q   <= (cnt_q < 6'd31);
            ram_addr_q <= (cnt_q < 6'd31) ? {bank_q, 5'(cnt_q[4:0] + 5'd1), 2'b00} : 8'd0;
            // Last compare (idx 31) happens at cnt 33; skip DRAIN if nothing is left.
            if (cnt_q == 6'd33) state_q <= (count_d == 5'd0) ? IDLE : DRAIN;
          end
          DRAIN:   if (count_d == 5'd0) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
`ifdef OBJSCH_OVF_STICKY_EN
      if (drop)         ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
`else
      if (line_start)   ovf_q <= 1'b0;
      else if (drop)    ovf_q <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_obj_line_sched.sv
// tb/tb_obj_line_sched.sv - scoreboard bench for obj_line_sched

module tb_obj_line_sched;

`ifdef OBJSCH_OVF_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       nRESET = 1'b0;
  logic       line_start = 1'b0;
  logic [7:0] vpos = '0;
  logic       objex = 1'b0;
  logic       objoff = 1'b1;
  logic [7:0] ram_addr;
  logic       ram_rd;
  logic [7:0] ram_q = '0;
  logic       draw_req;
  logic [4:0] draw_idx;
  logic [3:0] draw_row;
  logic       draw_ack = 1'b0;
  logic       lnsl, busy, ovf, line_late;
  logic [4:0] line_objs;
  logic       ovf_clr = 1'b0;

  obj_line_sched dut (
    .clkm_48MHZ(clk), .nRESET(nRESET), .line_start(line_start), .vpos(vpos),
    .objex(objex), .objoff(objoff), .ram_addr(ram_addr), .ram_rd(ram_rd),
    .ram_q(ram_q), .draw_req(draw_req), .draw_idx(draw_idx), .draw_row(draw_row),
    .draw_ack(draw_ack), .lnsl(lnsl), .busy(busy), .line_objs(line_objs),
    .ovf(ovf), .line_late(line_late), .ovf_clr(ovf_clr)
  );

  always #10 clk = ~clk;

  // Object RAM: two-stage read pipeline, data two cycles after the strobe.
  logic [7:0] ymem [2][32];
  logic [7:0] rd1 = '0;
  always @(posedge clk) begin
    rd1   <= ram_rd ? ymem[ram_addr[7]][ram_addr[6:2]] : 8'h00;
    ram_q <= rd1;
  end

  int n_chk = 0;
  int n_fail = 0;
  logic [8:0] sb [$];
  logic lnsl_m = 1'b0;
  logic ovf_m = 1'b0;
  int exp_objs;
  logic exp_drop;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every transfer against the scoreboard and checks the
  // head entry stays put while the request is pending.
  logic       prev_req = 1'b0, prev_ack = 1'b0;
  logic [8:0] prev_head = '0;
  always @(negedge clk) begin
    if (nRESET) begin
      if (prev_req && !prev_ack && draw_req)
        chk("head_stable", {draw_idx, draw_row}, prev_head);
      if (draw_req && draw_ack) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_xfer idx=%0d row=%0d expected=none", draw_idx, draw_row);
        end else begin
          logic [8:0] e;
          e = sb.pop_front();
          chk("xfer_idx", draw_idx, e[8:4]);
          chk("xfer_row", draw_row, e[3:0]);
        end
      end
      prev_req  = draw_req;
      prev_ack  = draw_ack;
      prev_head = {draw_idx, draw_row};
    end
  end

  // Reference: every object whose span covers vpos+1 is queued in index order;
  // without pops the queue keeps only the first 16.
  task automatic load_expect(input int mode);
    int n = 0;
    sb.delete();
    for (int i = 0; i < 32; i++) begin
      int s;
      s = (ymem[objex][i] + vpos + 1) % 256;
      if (objoff && (s / 16 == 15)) begin
        if (mode != 1 || n < 16) sb.push_back({5'(i), 4'(s % 16)});
        n++;
      end
    end
    exp_objs = (n > 16) ? 16 : n;
    exp_drop = (mode == 1) && (n > 16);
  endtask

  task automatic pulse_line();
    line_start = 1'b1;
    @(posedge clk); #1;
    line_start = 1'b0;
    lnsl_m = ~lnsl_m;
    chk("lnsl", lnsl, lnsl_m);
  endtask

  // mode 0: ack held high, 1: ack low until scan done, 2: random ack
  task automatic finish_line(input int mode, output int busy_cyc, output bit req_seen);
    busy_cyc = 0;
    req_seen = 0;
    while (busy && busy_cyc < 400) begin
      if (draw_req) req_seen = 1;
      if (mode == 1) draw_ack = (busy_cyc >= 40);
      else if (mode == 2) draw_ack = 1'($urandom_range(0, 1));
      else draw_ack = 1'b1;
      @(posedge clk); #1;
      busy_cyc++;
    end
    draw_ack = 1'b0;
    if (busy_cyc >= 400) begin
      n_chk++; n_fail++;
      $display("FAIL line_timeout busy still high after %0d cycles", busy_cyc);
    end
    chk("sb_drained", sb.size(), 0);
    chk("line_objs", line_objs, exp_objs);
    ovf_m = STICKY ? (ovf_m | exp_drop) : exp_drop;
    chk("ovf", ovf, ovf_m);
  endtask

  task automatic run_line(input int mode, output int busy_cyc, output bit req_seen);
    draw_ack = (mode != 1);
    load_expect(mode);
    pulse_line();
    finish_line(mode, busy_cyc, req_seen);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [7:0] y);
    for (int b = 0; b < 2; b++) for (int i = 0; i < 32; i++) ymem[b][i] = y;
  endtask

  task automatic pulse_clr();
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    if (STICKY) ovf_m = 1'b0;
    chk("ovf_after_clr", ovf, ovf_m);
  endtask

  int  bc;
  bit  rs;

  initial begin
    fill(8'h00);
    #15;
    chk("rst_ram_rd", ram_rd, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_draw_req", draw_req, 0);
    chk("rst_draw_head", {draw_idx, draw_row}, 0);
    chk("rst_lnsl", lnsl, 0);
    chk("rst_busy", busy, 0);
    chk("rst_line_objs", line_objs, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_line_late", line_late, 0);
    repeat (3) @(posedge clk);
    #1 nRESET = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_after_rst_busy", busy, 0);
    chk("idle_after_rst_rd", ram_rd, 0);

    // single object: vpos 0x10, obj 3 at Y=0xDF
    vpos = 8'h10; objex = 1'b0; objoff = 1'b1;
    ymem[0][3] = 8'hDF;
    run_line(0, bc, rs);
    chk("single_objs", line_objs, 1);

    // all in range, ack held: all 32 stream out, no overflow
    fill(8'hEF); vpos = 8'h00; objex = 1'b1;
    run_line(0, bc, rs);

    // all in range, no ack during scan: first 16 kept, ovf
    objex = 1'b0;
    run_line(1, bc, rs);
    chk("ovf_full", ovf, 1);
    pulse_clr();

    // clean line afterwards
    fill(8'h00);
    run_line(0, bc, rs);

    // objects disabled: scan runs 34 cycles, nothing requested
    fill(8'hEF); objoff = 1'b0;
    run_line(0, bc, rs);
    chk("objoff_busy_cycles", bc, 34);
    chk("objoff_req_seen", rs, 0);
    objoff = 1'b1;

    // overflow persistence across a clean line
    run_line(1, bc, rs);
    fill(8'h00);
    run_line(0, bc, rs);
    chk("ovf_next_line", ovf, STICKY ? 1 : 0);
    pulse_clr();

    // abort 10 cycles into scan
    fill(8'hEF); vpos = 8'h00;
    draw_ack = 1'b0;
    load_expect(0);
    pulse_line();
    repeat (9) @(posedge clk);
    #1;
    line_start = 1'b1;
    #1;
    chk("abort_req_same_cycle", draw_req, 0);
    @(posedge clk); #1;
    line_start = 1'b0;
    lnsl_m = ~lnsl_m;
    chk("abort_line_late", line_late, 1);
    chk("abort_draw_req", draw_req, 0);
    chk("abort_lnsl", lnsl, lnsl_m);
    chk("abort_ram_rd", ram_rd, 1);
    chk("abort_restart_idx", ram_addr[6:2], 0);
    @(posedge clk); #1;
    chk("late_one_cycle", line_late, 0);
    finish_line(0, bc, rs);
    repeat (2) @(posedge clk);
    #1;

    // randomized lines
    for (int l = 0; l < 20; l++) begin
      int mode, n;
      vpos  = 8'($urandom);
      objex = 1'($urandom);
      objoff = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < 32; i++)
        ymem[objex][i] = $urandom_range(0, 1) ? 8'((8'hF0 | 8'($urandom_range(0, 15))) - vpos - 8'd1)
                                               : 8'($urandom);
      mode = $urandom_range(0, 2);
      n = 0;
      for (int i = 0; i < 32; i++)
        if ((ymem[objex][i] + vpos + 1) % 256 >= 240) n++;
      if (mode == 2 && n > 16) mode = 0;
      run_line(mode, bc, rs);
      if (ovf_m) pulse_clr();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/obj_line_sched.md
OBJ_LINE_SCHED -- requirements
Module: obj_line_sched

Interface
REQ-001 Port: clkm_48MHZ  in  1  sole clock; all state updates on rising edge.
REQ-002 Port: nRESET  in  1  asynchronous, active-low reset.
REQ-003 Port: line_start  in  1  one-cycle pulse at start of each scanline.
REQ-004 Port: vpos  in  8  current vertical count; sampled on line_start.
REQ-005 Port: objex  in  1  object RAM bank select; sampled on line_start.
REQ-006 Port: objoff  in  1  0 = objects disabled; scan runs but queues nothing.
REQ-007 Port: ram_addr  out  8  object RAM address {bank, idx[4:0], 2'b00} (Y byte).
REQ-008 Port: ram_rd  out  1  read strobe; ram_q valid exactly 2 cycles later.
REQ-009 Port: ram_q  in  8  object RAM read data.
REQ-010 Port: draw_req  out  1  queued object available to the draw engine.
REQ-011 Port: draw_idx  out  5  object index of the head entry.
REQ-012 Port: draw_row  out  4  row within the 16-line object for the head entry.
REQ-013 Port: draw_ack  in  1  draw engine accepts the head entry.
REQ-014 Port: lnsl  out  1  line-buffer select; toggles each line.
REQ-015 Port: busy  out  1  scan or drain in progress.
REQ-016 Port: line_objs  out  5  count of objects queued this line (saturates at 16).
REQ-017 Port: ovf  out  1  more than 16 in-range objects found on a line.
REQ-018 Port: line_late  out  1  line_start arrived before previous line drained.
REQ-019 Port: ovf_clr  in  1  clears sticky ovf (used only with OBJSCH_OVF_STICKY_EN).

Function
REQ-020 States SHALL be IDLE, SCAN, DRAIN; any state SHALL go to SCAN on line_start.
REQ-021 On line_start: latch vpos and objex, toggle lnsl, flush FIFO, zero line_objs, set idx=0.
REQ-022 SCAN SHALL issue one ram_rd per cycle for idx 0..31 ascending (32 consecutive cycles).
REQ-023 Each returned byte Y: sum = Y + vpos_latched + 1, modulo 256; in range iff sum[7:4]==4'hF; row = sum[3:0].
REQ-024 In-range entries with objoff=1 SHALL be pushed {idx,row} into a 16-deep FIFO in index order.
REQ-025 Push when FIFO full SHALL be dropped and SHALL set ovf; line_objs saturates at 16.
REQ-026 SCAN SHALL go to DRAIN one cycle after the compare of idx 31 (34 cycles after entry).
REQ-027 DRAIN SHALL go to IDLE when FIFO empty; busy=1 in SCAN and DRAIN only.
REQ-028 draw_req = FIFO not empty in SCAN or DRAIN; draw_idx/draw_row SHALL hold stable until draw_ack.
REQ-029 Transfer occurs on draw_req & draw_ack; simultaneous push and pop SHALL both take effect.
REQ-030 draw_ack with draw_req=0 SHALL be ignored.
REQ-031 line_start while busy SHALL abort, discard queued entries, drop draw_req same cycle, set line_late for one cycle.
REQ-032 Reads in flight at abort SHALL be discarded (not compared).

Reset
REQ-033 nRESET low: state IDLE, FIFO empty, lnsl=0, ram_rd=0, ram_addr=0, draw_req=0, draw_idx=0, draw_row=0, busy=0, line_objs=0, ovf=0, line_late=0.
REQ-034 Reset deassertion mid-line SHALL wait for next line_start before scanning.

Configuration
REQ-035 Macro OBJSCH_OVF_STICKY_EN defined: ovf set stays 1 until ovf_clr=1 (set wins on same cycle).
REQ-036 Macro undefined: ovf cleared on every line_start; ovf_clr ignored.

Verification
REQ-037 vpos=0x10, obj 3 Y=0xDF, others 0x00 -> one entry idx=3 row=0, line_objs=1.
REQ-038 All 32 Y=0xEF, vpos=0x00, draw_ack=1 held -> draw_idx 0..31 in order, rows 0, ovf=0 only if pops keep FIFO below 16.
REQ-039 All 32 in range, draw_ack=0 -> line_objs=16, ovf=1, FIFO holds idx 0..15.
REQ-040 objoff=0 with all in range -> draw_req never asserts, busy high 34 cycles.
REQ-041 line_start 10 cycles into SCAN -> line_late pulse, draw_req=0 next cycle, lnsl toggles, scan restarts at idx 0.
REQ-042 With OBJSCH_OVF_STICKY_EN, ovf=1 persists across next line until ovf_clr pulse; without, clears on line_start.
